// File: rtl/ahb_modport_slave.sv
// AHB single-slave RAM target: byte/half/word access, programmable OKAY wait states, two-cycle ERROR.
// Latency: WAIT_STATES+1 cycles per OKAY data phase, 2 cycles for ERROR; HREADY low stalls the master.
module ahb_modport_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);
    localparam logic [3:0]  WS_INIT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      be_q, be_d;
    logic            write_q, write_d;

    logic [31:0]     mem_q [MEM_DEPTH];

    logic [31:0]     offset;
    logic            req_vld;
    logic            in_range;
    logic            size_ok;
    logic            req_err;
    logic            sample;
    logic [3:0]      be_req;

    // BASE_ADDR is aligned, so an address below it wraps to a huge offset and fails the range test.
    assign offset   = HADDR - BASE_ADDR;
    assign req_vld  = HTRANS[1];
    assign in_range = (offset < MEM_BYTES);
    assign req_err  = !in_range || !size_ok;
    assign sample   = (state_q != ST_WAIT) && (state_q != ST_ERR1);

    always_comb begin
        size_ok = 1'b0;
        be_req  = 4'b0000;
        case (HSIZE)
            3'd0: begin
                size_ok = 1'b1;
                be_req  = 4'b0001 << offset[1:0];
            end
            3'd1: begin
                size_ok = !offset[0];
                be_req  = offset[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                size_ok = (offset[1:0] == 2'b00);
                be_req  = 4'b1111;
            end
            default: begin
                size_ok = 1'b0;
                be_req  = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        HREADY  = 1'b1;
        HRESP   = RESP_OKAY;

        case (state_q)
            ST_WAIT: begin
                HREADY = 1'b0;
                if (wcnt_q == 4'd0) begin
                    state_d = ST_LAST;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADY  = 1'b0;
                HRESP   = RESP_ERR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = RESP_ERR;
            end
            default: ;
        endcase

        // Every HREADY=1 cycle doubles as the next address phase.
        if (sample) begin
            state_d = ST_IDLE;
            write_d = 1'b0;
            if (req_vld) begin
                idx_d = offset[AW+1:2];
                be_d  = be_req;
                if (req_err) begin
                    state_d = ST_ERR1;
                end else begin
                    write_d = HWRITE;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_INIT;
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // RAM has no reset; a reset edge coinciding with the commit edge discards the write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state_q == ST_LAST) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = (((state_q == ST_WAIT) || (state_q == ST_LAST)) && !write_q) ? mem_q[idx_q] : 32'h0;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb_modport_slave.sv
// Directed bench for ahb_modport_slave: one instance with zero wait states, one with two.
// A pipelined bus driver records per-beat stall count, response and read data for checking.
module tb_ahb_modport_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        tgt;

    logic [1:0]  htrans0, htrans2;
    logic        hready0, hready2;
    logic [1:0]  hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;

    assign htrans0 = tgt ? 2'b00 : htrans;
    assign htrans2 = tgt ? htrans : 2'b00;
    assign rdy     = tgt ? hready2 : hready0;
    assign resp    = tgt ? hresp2 : hresp0;
    assign rdata   = tgt ? hrdata2 : hrdata0;

    ahb_modport_slave #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(hreset), .HTRANS(htrans0), .HBURST(hburst), .HSIZE(hsize),
        .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_modport_slave #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESET(hreset), .HTRANS(htrans2), .HBURST(hburst), .HSIZE(hsize),
        .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] b_addr  [8];
    logic [31:0] b_wdata [8];
    logic [2:0]  b_size  [8];
    logic        b_wr    [8];
    int          r_lo      [8];
    logic [1:0]  r_lo_resp [8];
    logic [1:0]  r_resp    [8];
    logic [31:0] r_data    [8];

    task automatic beat(input int i, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d);
        b_wr[i]    = wr;
        b_addr[i]  = a;
        b_size[i]  = sz;
        b_wdata[i] = d;
    endtask

    task automatic run(input int n, input logic [2:0] burst);
        int ai;
        int di;
        int cyc;
        bit done;
        for (int i = 0; i < 8; i++) begin
            r_lo[i]      = 0;
            r_lo_resp[i] = 2'b00;
            r_resp[i]    = 2'b00;
            r_data[i]    = 32'h0;
        end
        ai   = 0;
        di   = -1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ai < n) begin
                htrans = (ai == 0) ? 2'b10 : 2'b11;
                haddr  = b_addr[ai];
                hsize  = b_size[ai];
                hwrite = b_wr[ai];
                hburst = burst;
            end else begin
                htrans = 2'b00;
                hwrite = 1'b0;
            end
            hwdata = (di >= 0) ? b_wdata[di] : 32'h0;
            #1;
            if (di >= 0) begin
                if (!rdy) begin
                    r_lo[di]++;
                    r_lo_resp[di] = r_lo_resp[di] | resp;
                end else begin
                    r_resp[di] = resp;
                    r_data[di] = rdata;
                end
            end
            if (rdy) begin
                if (ai < n) begin
                    di = ai;
                    ai++;
                end else begin
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        tgt    = 1'b0;
        hreset = 1'b1;
        htrans = 2'b00;
        hburst = 3'b000;
        hsize  = 3'd2;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hwdata = 32'h0;

        // Reset held for two edges.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_hready0", {31'b0, hready0}, 32'd1);
        chk("rst_hresp0",  {30'b0, hresp0},  32'd0);
        chk("rst_hrdata0", hrdata0,          32'h0);
        chk("rst_hready2", {31'b0, hready2}, 32'd1);
        chk("rst_hrdata2", hrdata2,          32'h0);
        hreset = 1'b0;

        // Word write then read, back to back.
        beat(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        beat(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run(2, 3'b001);
        chk("ww_lo",   r_lo[0],  0);
        chk("wr_lo",   r_lo[1],  0);
        chk("wr_resp", {30'b0, r_resp[1]}, 32'd0);
        chk("wr_data", r_data[1], 32'hDEADBEEF);

        // Byte lane 1, then halfword upper lanes, over a zeroed word.
        beat(0, 1'b1, 32'h20, 3'd2, 32'h0000_0000);
        beat(1, 1'b1, 32'h21, 3'd0, 32'hAAAA_AAAA);
        beat(2, 1'b0, 32'h20, 3'd2, 32'h0);
        beat(3, 1'b1, 32'h22, 3'd1, 32'h5678_1111);
        beat(4, 1'b0, 32'h20, 3'd2, 32'h0);
        run(5, 3'b001);
        chk("byte_data", r_data[2], 32'h0000_AA00);
        chk("half_data", r_data[4], 32'h5678_AA00);
        chk("half_lo",   r_lo[3],   0);

        // Out of range write must not alias onto word 0.
        beat(0, 1'b1, 32'h0,   3'd2, 32'h1111_1111);
        beat(1, 1'b1, 32'h400, 3'd2, 32'h2222_2222);
        beat(2, 1'b0, 32'h0,   3'd2, 32'h0);
        run(3, 3'b001);
        chk("oor_lo",      r_lo[1], 1);
        chk("oor_lo_resp", {30'b0, r_lo_resp[1]}, 32'd1);
        chk("oor_resp",    {30'b0, r_resp[1]},    32'd1);
        chk("oor_rdata",   r_data[1], 32'h0);
        chk("oor_ram",     r_data[2], 32'h1111_1111);
        chk("oor_next_lo", r_lo[2],   0);

        // Misaligned and unsupported sizes.
        beat(0, 1'b1, 32'h02, 3'd2, 32'h3333_3333);
        beat(1, 1'b0, 32'h04, 3'd3, 32'h0);
        beat(2, 1'b0, 32'h01, 3'd1, 32'h0);
        beat(3, 1'b0, 32'h22, 3'd1, 32'h0);
        beat(4, 1'b0, 32'h0,  3'd2, 32'h0);
        run(5, 3'b001);
        chk("mis_word_lo",   r_lo[0], 1);
        chk("mis_word_resp", {30'b0, r_lo_resp[0], r_resp[0]}, 32'b0101);
        chk("size3_resp",    {30'b0, r_lo_resp[1], r_resp[1]}, 32'b0101);
        chk("size3_rdata",   r_data[1], 32'h0);
        chk("mis_half_resp", {30'b0, r_lo_resp[2], r_resp[2]}, 32'b0101);
        chk("ok_half_data",  r_data[3], 32'h5678_AA00);
        chk("ok_half_resp",  {30'b0, r_resp[3]}, 32'd0);
        chk("mis_ram",       r_data[4], 32'h1111_1111);

        // Last word in range.
        beat(0, 1'b1, 32'h3FC, 3'd2, 32'hCAFE_F00D);
        beat(1, 1'b0, 32'h3FC, 3'd2, 32'h0);
        run(2, 3'b001);
        chk("top_resp", {30'b0, r_resp[0]}, 32'd0);
        chk("top_data", r_data[1], 32'hCAFE_F00D);

        // Two wait states: INCR4 writes then INCR4 reads.
        tgt = 1'b1;
        for (int i = 0; i < 4; i++) beat(i, 1'b1, 32'h40 + 32'(4*i), 3'd2, 32'hA5A5_0000 + 32'(i*257));
        run(4, 3'b011);
        for (int i = 0; i < 4; i++) chk($sformatf("ws_wr_lo%0d", i), r_lo[i], 2);
        for (int i = 0; i < 4; i++) beat(i, 1'b0, 32'h40 + 32'(4*i), 3'd2, 32'h0);
        run(4, 3'b011);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ws_rd_lo%0d", i),   r_lo[i],   2);
            chk($sformatf("ws_rd_data%0d", i), r_data[i], 32'hA5A5_0000 + 32'(i*257));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
